// File: rtl/trigger_responder_pkg.sv
// rtl/trigger_responder_pkg.sv - shared state encoding and default constants for the trigger responder
package trigger_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_DRIVE    = 2'b01,
    S_COOLDOWN = 2'b10
  } state_t;

  localparam int PULSE_LEN_DEF = 8;
  localparam int COOLDOWN_DEF  = 4;
  localparam int CNT_W_DEF     = 8;
  localparam int DUR_W         = 8;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-cycle rising-edge detector on a clock-synchronous level
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic history;
  logic armed;

  // armed masks the first edge after reset so a level already high is never taken as an edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      history <= 1'b0;
      armed   <= 1'b0;
    end else begin
      history <= level;
      armed   <= 1'b1;
    end
  end

  assign rise = armed & level & ~history;

endmodule

// File: rtl/trigger_responder.sv
// rtl/trigger_responder.sv - trigger-to-actuator pulse sequencer with cooldown, event count and overrun flag
module trigger_responder
  import trigger_responder_pkg::*;
#(
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int COOLDOWN  = COOLDOWN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             gatilho,
  input  logic             enable,
  input  logic             clr_overrun,
  output logic             acionar,
  output logic             busy,
  output logic             ack,
  output logic [CNT_W-1:0] evento_count,
  output logic             overrun
);

  localparam logic [DUR_W-1:0] PULSE_TERM = DUR_W'(PULSE_LEN);
  localparam logic [DUR_W-1:0] COOL_TERM  = DUR_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state, state_next;
  logic [DUR_W-1:0] dur, dur_next;
  logic             trig;
  logic             trig_en;
  logic             accept;
  logic             drop;

  rise_detect u_rise_detect (
    .clock (clock),
    .reset (reset),
    .level (gatilho),
    .rise  (trig)
  );

  assign trig_en = trig & enable;

  // dur counts 1..TERM inside a state so the cycles spent there equal the parameter
  always_comb begin
    state_next = state;
    dur_next   = dur;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig_en) begin
          accept     = 1'b1;
          state_next = S_DRIVE;
          dur_next   = DUR_W'(1);
        end
      end
      S_DRIVE: begin
        drop = trig_en;
        if (dur == PULSE_TERM) begin
          state_next = S_COOLDOWN;
          dur_next   = DUR_W'(1);
        end else begin
          dur_next = dur + DUR_W'(1);
        end
      end
      S_COOLDOWN: begin
        drop = trig_en;
        if (dur == COOL_TERM) begin
          state_next = S_IDLE;
          dur_next   = '0;
        end else begin
          dur_next = dur + DUR_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        dur_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      dur   <= '0;
    end else begin
      state <= state_next;
      dur   <= dur_next;
    end
  end

  // outputs are flops fed from the next state so they line up with the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acionar      <= 1'b0;
      busy         <= 1'b0;
      ack          <= 1'b0;
      evento_count <= '0;
      overrun      <= 1'b0;
    end else begin
      acionar <= (state_next == S_DRIVE);
      busy    <= (state_next != S_IDLE);
      ack     <= accept;
      if (accept && (evento_count != CNT_MAX)) begin
        evento_count <= evento_count + CNT_W'(1);
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trigger_responder.sv
// tb/tb_trigger_responder.sv - directed scoreboard bench for trigger_responder in three parameterisations
module tb_trigger_responder;
  import trigger_responder_pkg::*;

  typedef struct {
    string      tag;
    logic       a;
    logic       b;
    logic       k;
    logic [7:0] c;
    logic       o;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       g   [3];
  logic       en  [3];
  logic       clr [3];
  logic       act [3];
  logic       bsy [3];
  logic       ak  [3];
  logic       ov  [3];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  trigger_responder #(.PULSE_LEN(PULSE_LEN_DEF), .COOLDOWN(COOLDOWN_DEF), .CNT_W(CNT_W_DEF)) dut0 (
    .clock(clock), .reset(reset), .gatilho(g[0]), .enable(en[0]), .clr_overrun(clr[0]),
    .acionar(act[0]), .busy(bsy[0]), .ack(ak[0]), .evento_count(cnt0), .overrun(ov[0])
  );

  trigger_responder #(.PULSE_LEN(8), .COOLDOWN(4), .CNT_W(2)) dut1 (
    .clock(clock), .reset(reset), .gatilho(g[1]), .enable(en[1]), .clr_overrun(clr[1]),
    .acionar(act[1]), .busy(bsy[1]), .ack(ak[1]), .evento_count(cnt1), .overrun(ov[1])
  );

  trigger_responder #(.PULSE_LEN(1), .COOLDOWN(1), .CNT_W(8)) dut2 (
    .clock(clock), .reset(reset), .gatilho(g[2]), .enable(en[2]), .clr_overrun(clr[2]),
    .acionar(act[2]), .busy(bsy[2]), .ack(ak[2]), .evento_count(cnt2), .overrun(ov[2])
  );

  function automatic logic [7:0] count_of(input int d);
    case (d)
      0:       count_of = cnt0;
      1:       count_of = {6'b0, cnt1};
      default: count_of = cnt2;
    endcase
  endfunction

  task automatic chk(input string tag, input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk(tag, "acionar", {7'b0, act[d]}, 8'd0);
    chk(tag, "busy",    {7'b0, bsy[d]}, 8'd0);
    chk(tag, "ack",     {7'b0, ak[d]},  8'd0);
    chk(tag, "count",   count_of(d),    8'd0);
    chk(tag, "overrun", {7'b0, ov[d]},  8'd0);
  endtask

  task automatic step(input int d, input logic gv, input logic ev, input logic cv, input string tag,
                      input logic a, input logic b, input logic k, input logic [7:0] c, input logic o);
    exp_t e;
    g[d]   = gv;
    en[d]  = ev;
    clr[d] = cv;
    e.tag = tag; e.a = a; e.b = b; e.k = k; e.c = c; e.o = o;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk(e.tag, "acionar", {7'b0, act[d]}, {7'b0, e.a});
    chk(e.tag, "busy",    {7'b0, bsy[d]}, {7'b0, e.b});
    chk(e.tag, "ack",     {7'b0, ak[d]},  {7'b0, e.k});
    chk(e.tag, "count",   count_of(d),    e.c);
    chk(e.tag, "overrun", {7'b0, ov[d]},  {7'b0, e.o});
  endtask

  task automatic hold(input int d, input int n, input logic gv, input logic ev, input logic cv, input string tag,
                      input logic a, input logic b, input logic k, input logic [7:0] c, input logic o);
    for (int i = 0; i < n; i++) step(d, gv, ev, cv, tag, a, b, k, c, o);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      g[d] = 1'b0; en[d] = 1'b1; clr[d] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) chk_zero(d, "reset");
    reset = 1'b0;

    // single trigger held for 3 cycles
    step(0, 1'b0, 1'b1, 1'b0, "arm",   0, 0, 0, 8'd0, 0);
    step(0, 1'b1, 1'b1, 1'b0, "acc1",  1, 1, 1, 8'd1, 0);
    hold(0, 2, 1'b1, 1'b1, 1'b0, "drv1a", 1, 1, 0, 8'd1, 0);
    hold(0, 5, 1'b0, 1'b1, 1'b0, "drv1b", 1, 1, 0, 8'd1, 0);
    hold(0, 4, 1'b0, 1'b1, 1'b0, "cool1", 0, 1, 0, 8'd1, 0);
    step(0, 1'b0, 1'b1, 1'b0, "idle1", 0, 0, 0, 8'd1, 0);

    // retrigger during drive and on the final cooldown cycle
    step(0, 1'b1, 1'b1, 1'b0, "acc2",      1, 1, 1, 8'd2, 0);
    hold(0, 2, 1'b0, 1'b1, 1'b0, "drv2a",  1, 1, 0, 8'd2, 0);
    step(0, 1'b1, 1'b1, 1'b0, "ovr_drive", 1, 1, 0, 8'd2, 1);
    step(0, 1'b0, 1'b1, 1'b1, "clr_a",     1, 1, 0, 8'd2, 0);
    hold(0, 3, 1'b0, 1'b1, 1'b0, "drv2b",  1, 1, 0, 8'd2, 0);
    hold(0, 4, 1'b0, 1'b1, 1'b0, "cool2",  0, 1, 0, 8'd2, 0);
    step(0, 1'b1, 1'b1, 1'b1, "ovr_last_set_wins", 0, 0, 0, 8'd2, 1);
    step(0, 1'b0, 1'b1, 1'b1, "clr_b",     0, 0, 0, 8'd2, 0);

    // disabled triggers
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b1, 1'b0, 1'b0, "dis_hi", 0, 0, 0, 8'd2, 0);
      step(0, 1'b0, 1'b0, 1'b0, "dis_lo", 0, 0, 0, 8'd2, 0);
    end

    // reset in the 4th drive cycle with gatilho held high
    step(0, 1'b1, 1'b1, 1'b0, "acc3", 1, 1, 1, 8'd3, 0);
    hold(0, 3, 1'b1, 1'b1, 1'b0, "drv3", 1, 1, 0, 8'd3, 0);
    #2 reset = 1'b1;
    #1 chk_zero(0, "rst_mid");
    @(posedge clock);
    #1;
    chk_zero(0, "rst_hold");
    reset = 1'b0;
    hold(0, 3, 1'b1, 1'b1, 1'b0, "held_after_rst", 0, 0, 0, 8'd0, 0);
    step(0, 1'b0, 1'b1, 1'b0, "fall", 0, 0, 0, 8'd0, 0);
    step(0, 1'b1, 1'b1, 1'b0, "acc4", 1, 1, 1, 8'd1, 0);
    hold(0, 7, 1'b0, 1'b1, 1'b0, "drv4",  1, 1, 0, 8'd1, 0);
    hold(0, 4, 1'b0, 1'b1, 1'b0, "cool4", 0, 1, 0, 8'd1, 0);
    step(0, 1'b0, 1'b1, 1'b0, "idle4", 0, 0, 0, 8'd1, 0);

    // 2-bit counter saturation
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] c;
      c = (i > 3) ? 8'd3 : 8'(i);
      step(1, 1'b1, 1'b1, 1'b0, "sat_acc", 1, 1, 1, c, 0);
      hold(1, 7, 1'b0, 1'b1, 1'b0, "sat_drv",  1, 1, 0, c, 0);
      hold(1, 4, 1'b0, 1'b1, 1'b0, "sat_cool", 0, 1, 0, c, 0);
      step(1, 1'b0, 1'b1, 1'b0, "sat_idle", 0, 0, 0, c, 0);
    end

    // 1/1 timing with a trigger every 2 cycles
    for (int i = 0; i < 3; i++) begin
      logic       op;
      logic [7:0] c;
      op = (i != 0);
      c  = 8'(i + 1);
      step(2, 1'b1, 1'b1, 1'b0, "fast_acc",  1, 1, 1, c, op);
      step(2, 1'b0, 1'b1, 1'b0, "fast_cool", 0, 1, 0, c, op);
      step(2, 1'b1, 1'b1, 1'b0, "fast_drop", 0, 0, 0, c, 1);
      step(2, 1'b0, 1'b1, 1'b0, "fast_idle", 0, 0, 0, c, 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/trigger_responder.md
TRIGGER_RESPONDER -- requirements
Module: trigger_responder

Interface
REQ-001 The block SHALL have parameter PULSE_LEN, default 8, actuator drive length in clock cycles (legal range 1..255).
REQ-002 The block SHALL have parameter COOLDOWN, default 4, dead time after drive in clock cycles (legal range 1..255).
REQ-003 The block SHALL have parameter CNT_W, default 8, width of the event counter.
REQ-004 Port clock, input, 1, system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port gatilho, input, 1, trigger from the position monitor, synchronous to clock, any pulse width of 1 or more cycles.
REQ-007 Port enable, input, 1, level; when low, new triggers are ignored.
REQ-008 Port clr_overrun, input, 1, synchronous clear of the overrun flag.
REQ-009 Port acionar, output, 1, actuator drive, registered.
REQ-010 Port busy, output, 1, high while in DRIVE or COOLDOWN, registered.
REQ-011 Port ack, output, 1, one-cycle pulse confirming acceptance of a trigger, registered.
REQ-012 Port evento_count, output, CNT_W, number of accepted triggers, saturating.
REQ-013 Port overrun, output, 1, sticky flag: a trigger arrived while the block was busy.

Function
REQ-014 A trigger SHALL be a rising edge of gatilho: gatilho high at clock edge t and low at clock edge t-1; a held-high level SHALL count as one trigger.
REQ-015 The FSM SHALL have three states, IDLE, DRIVE and COOLDOWN, and SHALL enter IDLE on reset.
REQ-016 In IDLE, a trigger with enable=1 sampled at edge t SHALL cause entry to DRIVE at edge t.
REQ-016a On that trigger, acionar, busy and ack SHALL be high in the cycle after edge t, and evento_count SHALL increment at edge t.
REQ-017 ack SHALL be high for exactly one cycle per accepted trigger.
REQ-018 acionar SHALL remain high for exactly PULSE_LEN cycles.
REQ-018a After PULSE_LEN cycles the FSM SHALL enter COOLDOWN with acionar low and busy high.
REQ-019 busy SHALL remain high for exactly COOLDOWN cycles in COOLDOWN; the FSM SHALL then return to IDLE with busy low.
REQ-020 A trigger with enable=1 in DRIVE or COOLDOWN, including the final COOLDOWN cycle, SHALL be dropped (not counted, no ack, timing unchanged) and SHALL set overrun at that edge.
REQ-021 A trigger with enable=0 in any state SHALL be ignored and SHALL NOT set overrun.
REQ-022 Deasserting enable during DRIVE or COOLDOWN SHALL NOT abort the sequence.
REQ-023 clr_overrun=1 SHALL clear overrun at the next edge.
REQ-023a If a new overrun event and clr_overrun occur at the same edge, the set SHALL win.
REQ-024 evento_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024a Triggers accepted while evento_count is saturated SHALL still produce ack and the full drive sequence.
REQ-025 The internal duration counter SHALL be 8 bits wide; PULSE_LEN and COOLDOWN SHALL be loaded as terminal values with no off-by-one, so cycles counted equal the parameter value.
REQ-026 All outputs SHALL be driven from registers with no combinational path from input to output.

Reset
REQ-027 When reset is asserted, the following SHALL take effect asynchronously and within the same cycle: state=IDLE, acionar=0, busy=0, ack=0, evento_count=0, overrun=0, duration counter=0, edge-detect history register=0.
REQ-028 Reset asserted mid-DRIVE SHALL drop acionar immediately.
REQ-028a After release, no trigger SHALL be inferred from gatilho already high; a low-to-high transition SHALL be required.
REQ-029 Deassertion of reset SHALL be sampled by clock; the first trigger SHALL be accepted at the first edge after release that meets REQ-014.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, DRIVE=2'b01, COOLDOWN=2'b10) and the default constants for PULSE_LEN, COOLDOWN and CNT_W, for reuse by the position monitor and the bench.
REQ-031 One sub-module, rise_detect, SHALL implement the edge detection: 1-bit history register, asynchronous reset to 0, output high for one cycle per rising edge.
REQ-032 The FSM, duration counter, event counter and overrun flag SHALL reside in trigger_responder.

Verification
REQ-033 Reset release, then gatilho 0->1 held for 3 cycles with enable=1 -> ack 1 cycle; acionar high 8 cycles; busy high 12 cycles; evento_count=1; overrun=0.
REQ-034 Second gatilho edge 3 cycles into DRIVE, and another in the last COOLDOWN cycle -> no ack; timing unchanged; overrun=1; evento_count=1; clr_overrun pulse -> overrun=0.
REQ-035 enable=0 with 5 gatilho pulses -> acionar, ack and overrun stay 0; evento_count unchanged.
REQ-036 reset asserted on the 4th DRIVE cycle while gatilho is held high -> all outputs 0 immediately; no trigger accepted after release until gatilho falls and rises again.
REQ-037 CNT_W=2 with 5 spaced triggers -> evento_count reads 1,2,3,3,3; ack and acionar occur on all 5.
REQ-038 PULSE_LEN=1, COOLDOWN=1 with a trigger every 2 cycles -> alternate triggers accepted and the others flag overrun; busy never exceeds 2 cycles per acceptance.
